// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command/status and pad signals of the PS/2 host transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_strb;
    logic       tx_busy;
    logic       tx_done;
    logic [1:0] tx_status;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_data, tx_strb, ps2_clk_in, ps2_data_in,
        input  tx_busy, tx_done, tx_status, ps2_clk_oe, ps2_data_oe
    );

    modport slave (
        input  tx_data, tx_strb, ps2_clk_in, ps2_data_in,
        output tx_busy, tx_done, tx_status, ps2_clk_oe, ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_HOLD_CYCLES    = 50,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000,
    parameter int FILTER_LEN           = 4
) (
    input  logic            clk,
    input  logic            rst,
    ps2_host_tx_if.slave    bus
);
    localparam int          FW         = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] HOLD_LAST  = 20'(START_HOLD_CYCLES - 1);
    localparam logic [19:0] START_LAST = 20'(START_TIMEOUT_CYCLES - 1);
    localparam logic [19:0] XFER_LAST  = 20'(XFER_TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_START, S_WAIT_CLK, S_SEND,
        S_ACK, S_IDLE_WAIT, S_DONE, S_FAIL
    } state_t;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    sync1_q, sync2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          fall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
            fall_q    <= 1'b0;
        end else begin
            sync1_q <= {bus.ps2_data_in, bus.ps2_clk_in};
            sync2_q <= sync1_q;
            fall_q  <= filt_q[0] & ~sync2_q[0] & (fcnt_q[0] == FCNT_LAST);
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCNT_LAST) begin
                    fcnt_q[i] <= '0;
                    filt_q[i] <= sync2_q[i];
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t      state_q;
    logic [19:0] timer_q;
    logic [9:0]  shift_q;
    logic [3:0]  nbit_q;
    logic        nack_q;
    logic        clk_oe_q, data_oe_q, busy_q, done_q;
    logic [1:0]  status_q;

    // One timer serves every phase; it is the transfer timer from SEND onwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            shift_q   <= '0;
            nbit_q    <= '0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= 2'b00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.tx_strb) begin
                        shift_q  <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        clk_oe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        timer_q  <= '0;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (timer_q == INH_LAST) begin
                        timer_q   <= '0;
                        data_oe_q <= 1'b1;
                        state_q   <= S_START;
                    end else begin
                        timer_q <= timer_q + 20'd1;
                    end
                end
                S_START: begin
                    if (timer_q == HOLD_LAST) begin
                        timer_q  <= '0;
                        clk_oe_q <= 1'b0;
                        state_q  <= S_WAIT_CLK;
                    end else begin
                        timer_q <= timer_q + 20'd1;
                    end
                end
                S_WAIT_CLK: begin
                    if (fall_q) begin
                        data_oe_q <= ~shift_q[0];
                        shift_q   <= {1'b0, shift_q[9:1]};
                        nbit_q    <= 4'd1;
                        timer_q   <= '0;
                        state_q   <= S_SEND;
                    end else if (timer_q == START_LAST) begin
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        status_q  <= 2'b10;
                        state_q   <= S_FAIL;
                    end else begin
                        timer_q <= timer_q + 20'd1;
                    end
                end
                S_SEND, S_ACK, S_IDLE_WAIT: begin
                    if (timer_q == XFER_LAST) begin
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                        status_q  <= 2'b11;
                        state_q   <= S_FAIL;
                    end else begin
                        timer_q <= timer_q + 20'd1;
                        if (state_q == S_SEND && fall_q) begin
                            data_oe_q <= ~shift_q[0];
                            shift_q   <= {1'b0, shift_q[9:1]};
                            nbit_q    <= nbit_q + 4'd1;
                            if (nbit_q == 4'd9) state_q <= S_ACK;
                        end else if (state_q == S_ACK && fall_q) begin
                            nack_q  <= filt_q[1];
                            state_q <= S_IDLE_WAIT;
                        end else if (state_q == S_IDLE_WAIT && (&filt_q)) begin
                            done_q   <= 1'b1;
                            status_q <= {1'b0, nack_q};
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE, S_FAIL: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_done     = done_q;
    assign bus.tx_status   = status_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    localparam int INH   = 40;
    localparam int HOLD  = 8;
    localparam int STO   = 300;
    localparam int XTO   = 1500;
    localparam int FLEN  = 4;
    localparam int HALF  = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    int   dev_edges = 0;
    bit   dev_abort = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ps2_host_tx_if bus ();

    assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .START_HOLD_CYCLES(HOLD),
        .START_TIMEOUT_CYCLES(STO), .XFER_TIMEOUT_CYCLES(XTO), .FILTER_LEN(FLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int       cyc = 0, clk_oe_cnt = 0, inh_cnt = 0, done_cnt = 0;
    int       done_cyc = 0, wait_entry_cyc = 0, first_fall_cyc = 0;
    logic     prev_clk_oe = 1'b0, prev_data_oe = 1'b0, armed = 1'b0;
    logic [1:0] status_at_done = 2'b00, oe_at_done = 2'b00;

    always @(negedge clk) begin
        cyc          <= cyc + 1;
        prev_clk_oe  <= bus.ps2_clk_oe;
        prev_data_oe <= bus.ps2_data_oe;
        if (bus.ps2_clk_oe) clk_oe_cnt <= clk_oe_cnt + 1;
        if (bus.ps2_clk_oe && !bus.ps2_data_oe) inh_cnt <= inh_cnt + 1;
        if (prev_clk_oe && !bus.ps2_clk_oe) begin
            wait_entry_cyc <= cyc;
            armed          <= 1'b1;
        end
        if (armed && prev_data_oe && !bus.ps2_data_oe) begin
            first_fall_cyc <= cyc;
            armed          <= 1'b0;
        end
        if (bus.tx_done) begin
            done_cnt       <= done_cnt + 1;
            done_cyc       <= cyc;
            status_at_done <= bus.tx_status;
            oe_at_done     <= {bus.ps2_clk_oe, bus.ps2_data_oe};
        end
    end

    task automatic send(input logic [7:0] d);
        @(posedge clk); #1;
        bus.tx_data = d;
        bus.tx_strb = 1'b1;
        @(posedge clk); #1;
        bus.tx_strb = 1'b0;
    endtask

    task automatic dev_run(input int n_edges, input bit ack, input int glitch_after,
                           output logic [9:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!(bus.ps2_clk_oe === 1'b0 && bus.ps2_data_oe === 1'b1) && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t >= 200) return;
        for (int k = 1; k <= n_edges && k <= 11 && !dev_abort; k++) begin
            if (k == 11) begin
                repeat (HALF / 2) @(posedge clk);
                dev_data_low = ack;
                repeat (HALF / 2) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            dev_clk_low = 1'b1;
            dev_edges = k;
            repeat (HALF) @(posedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = bus.ps2_data_in;
            if (k == glitch_after) begin
                repeat (8) @(posedge clk);
                dev_clk_low = 1'b1;
                repeat (2) @(posedge clk);
                dev_clk_low = 1'b0;
            end
        end
        repeat (HALF) @(posedge clk);
        dev_data_low = 1'b0;
        dev_clk_low  = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input int limit, output bit ok);
        int t;
        t = 0;
        while (done_cnt == start_cnt && t < limit) begin
            @(posedge clk);
            t++;
        end
        ok = (done_cnt != start_cnt);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (bus.ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", bus.ps2_clk_oe); end
        checks++; if (bus.ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", bus.ps2_data_oe); end
        checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.tx_busy); end
        checks++; if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.tx_done); end
        checks++; if (bus.tx_status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want 00", bus.tx_status); end
    endtask

    task automatic test_ack_ed;
        logic [9:0] bits;
        int c0, i0, d0;
        bit ok;
        c0 = clk_oe_cnt; i0 = inh_cnt; d0 = done_cnt;
        fork
            begin
                send(8'hED);
                checks++; if (bus.ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL clk_oe_next_cycle: got %b want 1", bus.ps2_clk_oe); end
                checks++; if (bus.tx_busy !== 1'b1) begin errors++; $display("FAIL busy_after_strb: got %b want 1", bus.tx_busy); end
            end
            dev_run(11, 1'b1, 0, bits);
        join
        wait_done(d0, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ed_done_timeout: got no tx_done want tx_done"); end
        checks++; if (bits !== {1'b1, 1'b1, 8'hED}) begin errors++; $display("FAIL ed_bits: got %b want %b", bits, {1'b1, 1'b1, 8'hED}); end
        checks++; if (clk_oe_cnt - c0 != INH + HOLD) begin errors++; $display("FAIL ed_clk_oe_len: got %0d want %0d", clk_oe_cnt - c0, INH + HOLD); end
        checks++; if (inh_cnt - i0 != INH) begin errors++; $display("FAIL ed_data_oe_delay: got %0d want %0d", inh_cnt - i0, INH); end
        checks++; if (status_at_done !== 2'b00) begin errors++; $display("FAIL ed_status: got %b want 00", status_at_done); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ed_done_pulse: got %0d cycles want 1", done_cnt - d0); end
        checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL ed_busy_after: got %b want 0", bus.tx_busy); end
    endtask

    task automatic test_nack_f4;
        logic [9:0] bits;
        int d0;
        bit ok;
        d0 = done_cnt;
        fork
            send(8'hF4);
            dev_run(11, 1'b0, 0, bits);
        join
        wait_done(d0, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL f4_done_timeout: got no tx_done want tx_done"); end
        checks++; if (bits[8] !== 1'b0) begin errors++; $display("FAIL f4_parity: got %b want 0", bits[8]); end
        checks++; if (bits !== {1'b1, 1'b0, 8'hF4}) begin errors++; $display("FAIL f4_bits: got %b want %b", bits, {1'b1, 1'b0, 8'hF4}); end
        checks++; if (status_at_done !== 2'b01) begin errors++; $display("FAIL f4_status: got %b want 01", status_at_done); end
    endtask

    task automatic test_start_timeout;
        int d0;
        bit ok;
        d0 = done_cnt;
        send(8'h00);
        wait_done(d0, INH + HOLD + STO + 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sto_done_timeout: got no tx_done want tx_done"); end
        checks++; if (status_at_done !== 2'b10) begin errors++; $display("FAIL sto_status: got %b want 10", status_at_done); end
        checks++; if (done_cyc - wait_entry_cyc != STO) begin errors++; $display("FAIL sto_latency: got %0d want %0d", done_cyc - wait_entry_cyc, STO); end
        checks++; if (oe_at_done !== 2'b00) begin errors++; $display("FAIL sto_oe: got %b want 00", oe_at_done); end
    endtask

    task automatic test_glitch_busy;
        logic [9:0] bits;
        int d0, c1;
        bit ok;
        d0 = done_cnt;
        fork
            send(8'hED);
            dev_run(11, 1'b1, 3, bits);
            begin
                repeat (150) @(posedge clk); #1;
                bus.tx_data = 8'hAA;
                bus.tx_strb = 1'b1;
                @(posedge clk); #1;
                bus.tx_strb = 1'b0;
            end
        join
        wait_done(d0, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL glitch_done_timeout: got no tx_done want tx_done"); end
        checks++; if (bits !== {1'b1, 1'b1, 8'hED}) begin errors++; $display("FAIL glitch_bits: got %b want %b", bits, {1'b1, 1'b1, 8'hED}); end
        checks++; if (status_at_done !== 2'b00) begin errors++; $display("FAIL glitch_status: got %b want 00", status_at_done); end
        c1 = clk_oe_cnt;
        repeat (100) @(posedge clk); #1;
        checks++; if (clk_oe_cnt != c1) begin errors++; $display("FAIL busy_strb_ignored: got %0d clk_oe cycles want 0", clk_oe_cnt - c1); end
        checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL busy_strb_idle: got %b want 0", bus.tx_busy); end
    endtask

    task automatic test_xfer_timeout;
        logic [9:0] bits;
        int d0;
        bit ok;
        d0 = done_cnt;
        fork
            send(8'hED);
            dev_run(5, 1'b0, 0, bits);
        join
        wait_done(d0, XTO + 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL xto_done_timeout: got no tx_done want tx_done"); end
        checks++; if (status_at_done !== 2'b11) begin errors++; $display("FAIL xto_status: got %b want 11", status_at_done); end
        checks++; if (done_cyc - first_fall_cyc != XTO) begin errors++; $display("FAIL xto_latency: got %0d want %0d", done_cyc - first_fall_cyc, XTO); end
        checks++; if (oe_at_done !== 2'b00) begin errors++; $display("FAIL xto_oe: got %b want 00", oe_at_done); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] bits;
        int d0;
        bit ok;
        dev_edges = 0;
        dev_abort = 1'b0;
        fork
            send(8'hF4);
            dev_run(11, 1'b1, 0, bits);
            begin
                int t;
                t = 0;
                while (dev_edges < 5 && t < 2000) begin
                    @(posedge clk);
                    t++;
                end
                checks++; if (dev_edges < 5) begin errors++; $display("FAIL rst_mid_edge5: got %0d edges want 5", dev_edges); end
                repeat (10) @(posedge clk);
                @(negedge clk); #1;
                rst = 1'b0;
                dev_abort = 1'b1;
                #1;
                checks++; if ({bus.ps2_clk_oe, bus.ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL rst_mid_oe: got %b want 00", {bus.ps2_clk_oe, bus.ps2_data_oe}); end
                checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.tx_busy); end
                checks++; if (bus.tx_status !== 2'b00) begin errors++; $display("FAIL rst_mid_status: got %b want 00", bus.tx_status); end
            end
        join
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        dev_abort = 1'b0;
        repeat (5) @(posedge clk);
        d0 = done_cnt;
        fork
            send(8'hF4);
            dev_run(11, 1'b1, 0, bits);
        join
        wait_done(d0, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_resend_done: got no tx_done want tx_done"); end
        checks++; if (bits !== {1'b1, 1'b0, 8'hF4}) begin errors++; $display("FAIL rst_resend_bits: got %b want %b", bits, {1'b1, 1'b0, 8'hF4}); end
        checks++; if (status_at_done !== 2'b00) begin errors++; $display("FAIL rst_resend_status: got %b want 00", status_at_done); end
    endtask

    initial begin
        bus.tx_data = 8'h00;
        bus.tx_strb = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        test_ack_ed();
        test_nack_f4();
        test_start_timeout();
        test_glitch_busy();
        test_xfer_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
